// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program counter and instruction-fetch sequencer. It presents a word PC to
//   the program-address decoder and tags each issued PC as it travels through
//   the FETCH_LAT-cycle decoder/memory latency. Each returned instr_in word is
//   paired with its PC. The block handles sequential fetch, branch and jump
//   redirects, stall with replay, and a sticky fault for out-of-range fetches.
//
// Ports
//   clk, rst_n   clock (rising edge); asynchronous active-low reset
//   stall        downstream busy: outputs hold, in-flight fetches are replayed
//   branch_en    redirect to pc_out + 1 + sext(branch_off)
//   branch_off   signed 16-bit word offset
//   jump_en      redirect to zero-extended jump_target (wins over branch)
//   jump_target  26-bit absolute word address
//   instr_in     word returned by program memory, FETCH_LAT cycles after issue
//   pc_out       word address to the decoder; never above PROG_WORDS-1
//   instr_out    delivered instruction
//   instr_pc     PC of instr_out
//   instr_valid  instr_out/instr_pc carry a newly delivered instruction
//   fault        sticky out-of-range fetch fault, cleared only by rst_n
module pc_fetch_unit #(
  parameter int          ADDR_W     = 32,
  parameter int          PROG_WORDS = 1024,
  parameter int unsigned RESET_PC   = 0,
  parameter int          FETCH_LAT  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch_en,
  input  logic [15:0]       branch_off,
  input  logic              jump_en,
  input  logic [25:0]       jump_target,
  input  logic [31:0]       instr_in,
  output logic [ADDR_W-1:0] pc_out,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              fault
);

  localparam logic [ADDR_W-1:0] PC_MAX = ADDR_W'(PROG_WORDS - 1);
  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);
  localparam int                LAST   = FETCH_LAT - 1;

  typedef enum logic [1:0] {IDLE, RUN, HOLD, FLT} state_t;
  state_t state, state_nxt;

  // Fetch tags: stage i holds the PC issued i+1 cycles ago. The last stage
  // lines up with the instr_in word for that PC.
  logic [FETCH_LAT-1:0]             vld_pipe;
  logic [FETCH_LAT-1:0][ADDR_W-1:0] pc_pipe;

  // PC after the most recently delivered instruction. This is where a stall
  // resumes, because everything younger in flight is thrown away.
  logic [ADDR_W-1:0] next_exp;

  logic              redir;
  logic [ADDR_W-1:0] seq_pc, br_pc, redir_pc;

  assign redir    = (jump_en | branch_en) & (state != FLT);
  assign seq_pc   = pc_out + ADDR_W'(1);
  assign br_pc    = pc_out + ADDR_W'(1) + ADDR_W'($signed(branch_off));
  assign redir_pc = jump_en ? ADDR_W'(jump_target) : br_pc;

  // Control decode. A target above PC_MAX never reaches pc_out. Instead it
  // raises flt_set, and pc_out keeps its last legal value.
  logic              issue, clr, flt_set;
  logic [ADDR_W-1:0] pc_nxt;

  always_comb begin
    issue   = 1'b0;
    clr     = 1'b0;
    flt_set = 1'b0;
    pc_nxt  = pc_out;
    if (redir) begin
      clr = 1'b1;
      if (redir_pc > PC_MAX) flt_set = 1'b1;
      else                   pc_nxt  = redir_pc;
    end else if (state == RUN) begin
      if (stall) begin
        // Replay fault keeps the tags so older fetches still drain.
        if (next_exp > PC_MAX) flt_set = 1'b1;
        else begin
          clr    = 1'b1;
          pc_nxt = next_exp;
        end
      end else begin
        // The last legal PC is still issued even when its successor faults.
        issue = 1'b1;
        if (seq_pc > PC_MAX) flt_set = 1'b1;
        else                 pc_nxt  = seq_pc;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = (redir & stall) ? HOLD : RUN;
      RUN, HOLD: state_nxt = stall ? HOLD : RUN;
      default:   state_nxt = FLT;
    endcase
    if (flt_set) state_nxt = FLT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      pc_pipe  <= '0;
    end else begin
      vld_pipe[0] <= issue & ~clr;
      pc_pipe[0]  <= pc_out;
      for (int i = 1; i < FETCH_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1] & ~clr;
        pc_pipe[i]  <= pc_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out      <= PC_RST;
      next_exp    <= PC_RST;
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
    end else begin
      pc_out <= pc_nxt;
      if (flt_set) fault <= 1'b1;

      // A redirect kills the word in the last stage on this same edge.
      if (redir) begin
        instr_valid <= 1'b0;
      end else if (!stall) begin
        instr_valid <= vld_pipe[LAST];
        if (vld_pipe[LAST]) begin
          instr_out <= instr_in;
          instr_pc  <= pc_pipe[LAST];
        end
      end

      if (redir) begin
        if (!flt_set) next_exp <= redir_pc;
      end else if (!stall && vld_pipe[LAST]) begin
        next_exp <= pc_pipe[LAST] + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, hand-written corner
// sequences, and a randomized run checked against a transaction-level model.
module tb_pc_fetch_unit;

  localparam int          ADDR_W     = 32;
  localparam int          PROG_WORDS = 1024;
  localparam int          FETCH_LAT  = 2;
  localparam int unsigned RESET_PC   = 0;
  localparam logic [31:0] PMAX       = 32'(PROG_WORDS - 1);

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic              stall = 1'b0;
  logic              branch_en = 1'b0;
  logic [15:0]       branch_off = '0;
  logic              jump_en = 1'b0;
  logic [25:0]       jump_target = '0;
  logic [31:0]       instr_in;
  logic [ADDR_W-1:0] pc_out;
  logic [31:0]       instr_out;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              fault;

  int n_chk  = 0;
  int n_fail = 0;

  pc_fetch_unit #(
    .ADDR_W(ADDR_W), .PROG_WORDS(PROG_WORDS), .RESET_PC(RESET_PC), .FETCH_LAT(FETCH_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_en(branch_en),
    .branch_off(branch_off), .jump_en(jump_en), .jump_target(jump_target),
    .instr_in(instr_in), .pc_out(pc_out), .instr_out(instr_out),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(logic [31:0] a);
    return 32'hA000_0000 + a;
  endfunction

  // Decoder register followed by the memory register. This is not reset on
  // purpose, so stale data stays in flight across a reset.
  logic [31:0] dec_q = '0;
  logic [31:0] mem_q = '0;
  always @(posedge clk) begin
    dec_q <= pc_out;
    mem_q <= word_of(dec_q);
  end
  assign instr_in = mem_q;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, want %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // In-flight fetches are a queue of {pc, edges since issue}. A fetch pairs
  // with memory data once its age equals FETCH_LAT.
  typedef struct { logic [31:0] pc; int age; } fly_t;
  fly_t fly[$];
  localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_FAULT = 3;
  int          m_mode;
  logic [31:0] m_pc, m_nexp, m_iout, m_ipc;
  logic        m_iv, m_fault;

  task automatic model_reset();
    m_mode = M_IDLE; m_pc = RESET_PC; m_nexp = RESET_PC;
    m_iout = '0; m_ipc = '0; m_iv = 1'b0; m_fault = 1'b0;
    fly.delete();
  endtask

  task automatic model_edge();
    bit          redir, have;
    longint      t;
    logic [31:0] tgt;
    fly_t        head;
    redir = (jump_en || branch_en) && (m_mode != M_FAULT);
    if (jump_en) tgt = {6'b0, jump_target};
    else begin
      t   = longint'(m_pc) + 1 + longint'($signed(branch_off));
      tgt = t[31:0];
    end
    have = (fly.size() > 0) && (fly[0].age == FETCH_LAT);
    if (have) head = fly.pop_front();
    if (redir) m_iv = 1'b0;
    else if (!stall) begin
      m_iv = have;
      if (have) begin
        m_iout = word_of(head.pc); m_ipc = head.pc; m_nexp = head.pc + 1;
      end
    end
    foreach (fly[i]) fly[i].age++;
    if (m_mode == M_FAULT) begin
      // frozen except for draining
    end else if (redir) begin
      fly.delete();
      if (tgt > PMAX) begin m_fault = 1'b1; m_mode = M_FAULT; end
      else begin m_pc = tgt; m_nexp = tgt; m_mode = stall ? M_HOLD : M_RUN; end
    end else begin
      case (m_mode)
        M_IDLE: m_mode = M_RUN;
        M_HOLD: m_mode = stall ? M_HOLD : M_RUN;
        default: begin
          if (stall) begin
            if (m_nexp > PMAX) begin m_fault = 1'b1; m_mode = M_FAULT; end
            else begin fly.delete(); m_pc = m_nexp; m_mode = M_HOLD; end
          end else begin
            fly.push_back('{pc: m_pc, age: 1});
            if (m_pc + 1 > PMAX) begin m_fault = 1'b1; m_mode = M_FAULT; end
            else m_pc = m_pc + 1;
          end
        end
      endcase
    end
  endtask

  task automatic chk_model(string tag);
    chk ({tag, "_pc"},   pc_out,      m_pc);
    chk1({tag, "_iv"},   instr_valid, m_iv);
    chk ({tag, "_ipc"},  instr_pc,    m_ipc);
    chk ({tag, "_iout"}, instr_out,   m_iout);
    chk1({tag, "_flt"},  fault,       m_fault);
  endtask

  // Drive one cycle's inputs, take the edge, and sample on the falling edge.
  task automatic cyc(bit s, bit b, logic [15:0] bo, bit j, logic [25:0] jt);
    stall = s; branch_en = b; branch_off = bo; jump_en = j; jump_target = jt;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Called right after a falling edge. Reset is released well before the next rise.
  task automatic do_reset();
    stall = 1'b0; branch_en = 1'b0; jump_en = 1'b0; branch_off = '0; jump_target = '0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk ("rst_pc",   pc_out,      RESET_PC);
    chk1("rst_iv",   instr_valid, 1'b0);
    chk ("rst_ipc",  instr_pc,    32'h0);
    chk ("rst_iout", instr_out,   32'h0);
    chk1("rst_flt",  fault,       1'b0);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit s; bit b; logic [15:0] bo; bit j; logic [25:0] jt;
    logic [31:0] pc; bit iv; logic [31:0] ipc; bit flt;
  } vec_t;
  vec_t tbl[21];

  function automatic vec_t mk(bit s, bit b, int bo, bit j, int jt,
                              int pc, bit iv, int ipc, bit flt);
    vec_t v;
    v.s = s; v.b = b; v.bo = 16'(bo); v.j = j; v.jt = 26'(jt);
    v.pc = 32'(pc); v.iv = iv; v.ipc = 32'(ipc); v.flt = flt;
    return v;
  endfunction

  logic [31:0] dlv[$];
  int          flt_age;

  initial begin
    // Rows are cycles after reset release: inputs, then expected values after the edge.
    tbl[0]  = mk(0,0, 0,0,0,       0,     0, 0,     0); // IDLE holds 0
    tbl[1]  = mk(0,0, 0,0,0,       1,     0, 0,     0); // issue 0
    tbl[2]  = mk(0,0, 0,0,0,       2,     0, 0,     0);
    tbl[3]  = mk(0,0, 0,0,0,       3,     1, 0,     0); // first delivery, pc 0
    tbl[4]  = mk(0,0, 0,0,0,       4,     1, 1,     0);
    tbl[5]  = mk(0,1,-2,0,0,       3,     0, 1,     0); // branch 4+1-2
    tbl[6]  = mk(0,0, 0,0,0,       4,     0, 1,     0);
    tbl[7]  = mk(0,0, 0,0,0,       5,     0, 1,     0);
    tbl[8]  = mk(0,0, 0,0,0,       6,     1, 3,     0); // target word arrives
    tbl[9]  = mk(0,1, 5,1,'h100,   'h100, 0, 3,     0); // jump beats branch
    tbl[10] = mk(0,0, 0,0,0,       'h101, 0, 3,     0);
    tbl[11] = mk(0,0, 0,0,0,       'h102, 0, 3,     0);
    tbl[12] = mk(0,0, 0,0,0,       'h103, 1, 'h100, 0);
    tbl[13] = mk(1,0, 0,0,0,       'h101, 1, 'h100, 0); // stall: replay pc, hold out
    tbl[14] = mk(1,0, 0,0,0,       'h101, 1, 'h100, 0);
    tbl[15] = mk(0,0, 0,0,0,       'h101, 0, 'h100, 0); // release
    tbl[16] = mk(0,0, 0,0,0,       'h102, 0, 'h100, 0);
    tbl[17] = mk(0,0, 0,0,0,       'h103, 0, 'h100, 0);
    tbl[18] = mk(0,0, 0,0,0,       'h104, 1, 'h101, 0); // no skip after replay
    tbl[19] = mk(0,0, 0,1,'h400,   'h104, 0, 'h101, 1); // out-of-range jump
    tbl[20] = mk(0,0, 0,1,5,       'h104, 0, 'h101, 1); // ignored in fault

    #1;
    do_reset();
    foreach (tbl[k]) begin
      cyc(tbl[k].s, tbl[k].b, tbl[k].bo, tbl[k].j, tbl[k].jt);
      chk ($sformatf("tbl%0d_pc", k),  pc_out,      tbl[k].pc);
      chk1($sformatf("tbl%0d_iv", k),  instr_valid, tbl[k].iv);
      chk ($sformatf("tbl%0d_ipc", k), instr_pc,    tbl[k].ipc);
      chk1($sformatf("tbl%0d_flt", k), fault,       tbl[k].flt);
      if (tbl[k].iv) chk($sformatf("tbl%0d_iout", k), instr_out, word_of(tbl[k].ipc));
    end

    // Sequential run off the end of program space.
    do_reset();
    cyc(0, 0, '0, 1, 26'd1020);
    chk("seq_start_pc", pc_out, 32'd1020);
    dlv.delete();
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, '0, 0, '0);
      if (instr_valid) dlv.push_back(instr_pc);
    end
    chk ("seq_pc_top",  pc_out, 32'd1023);
    chk1("seq_flt_pre", fault,  1'b0);
    cyc(0, 0, '0, 0, '0);
    if (instr_valid) dlv.push_back(instr_pc);
    chk ("seq_pc_hold", pc_out, 32'd1023);
    chk1("seq_flt_set", fault,  1'b1);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, '0, 0, '0);
      if (instr_valid) dlv.push_back(instr_pc);
    end
    chk("seq_dlv_n", 32'(dlv.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("seq_dlv%0d", i), (i < dlv.size()) ? dlv[i] : 32'hFFFF_FFFF, 32'(1020 + i));
    cyc(0, 0, '0, 1, 26'd5);
    chk ("seq_jmp_ign", pc_out, 32'd1023);
    chk1("seq_flt_stk", fault,  1'b1);

    // Async reset while stalled in HOLD.
    do_reset();
    repeat (8) cyc(0, 0, '0, 0, '0);
    cyc(1, 0, '0, 0, '0);
    cyc(1, 0, '0, 0, '0);
    chk1("hold_iv",  instr_valid, 1'b1);
    chk ("hold_ipc", instr_pc,    32'd4);
    chk ("hold_pc",  pc_out,      32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk ("arst_pc",   pc_out,      RESET_PC);
    chk1("arst_iv",   instr_valid, 1'b0);
    chk ("arst_ipc",  instr_pc,    32'h0);
    chk ("arst_iout", instr_out,   32'h0);
    chk1("arst_flt",  fault,       1'b0);
    stall = 1'b0;
    @(negedge clk);
    do_reset();

    // Randomized run against the model.
    flt_age = 0;
    for (int n = 0; n < 3000; n++) begin
      bit          s, b, j;
      logic [15:0] bo;
      logic [25:0] jt;
      int          r;
      if (m_fault) flt_age++;
      if (flt_age > 6 || $urandom_range(0, 199) == 0) begin
        flt_age = 0;
        do_reset();
      end
      s = ($urandom_range(0, 99) < 15);
      b = ($urandom_range(0, 99) < 6);
      j = ($urandom_range(0, 99) < 3);
      r = int'($urandom_range(0, 9));
      bo = (r < 8) ? 16'($urandom_range(0, 40) - 20) : 16'($urandom());
      r = int'($urandom_range(0, 9));
      if (r < 5)      jt = 26'($urandom_range(0, 1023));
      else if (r < 8) jt = 26'($urandom_range(990, 1023));
      else            jt = 26'($urandom_range(1024, 3000));
      cyc(s, b, bo, j, jt);
      chk_model("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
